// File: rtl/fp_class_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_class_pkg
// Description : Class-vector type and class bit indices for fp_class_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_class_pkg;

    localparam int CLS_W = 10;

    typedef logic [CLS_W-1:0] cls_t;

    // Bit positions follow the RISC-V fclass result layout
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

endpackage
`default_nettype wire

// File: rtl/fp_class_lane.sv
`default_nettype none
// ============================================================================
// Module      : fp_class_lane
// Description : Combinational one-hot classifier for a single FP operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_class_lane
    import fp_class_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [SIGN_W-1:0] sign,
    input  logic [EXPO_W-1:0] expo,
    input  logic [MANT_W-1:0] mant,
    output cls_t              cls
);

    logic w_neg;
    logic w_exp_zero;
    logic w_exp_ones;
    logic w_mant_zero;
    logic w_quiet;

    assign w_neg       = sign[SIGN_W-1];
    assign w_exp_zero  = (expo == '0);
    assign w_exp_ones  = &expo;
    assign w_mant_zero = (mant == '0);
    // With a 1-bit mantissa the only NaN has this bit set, so it is always quiet
    assign w_quiet     = mant[MANT_W-1];

    always_comb begin
        cls = '0;
        if (w_exp_ones) begin
            if (w_mant_zero) begin
                cls[w_neg ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            end else begin
                cls[w_quiet ? CLS_QNAN : CLS_SNAN] = 1'b1;
            end
        end else if (w_exp_zero) begin
            if (w_mant_zero) begin
                cls[w_neg ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            end else begin
                cls[w_neg ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
            end
        end else begin
            cls[w_neg ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_class_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_class_pipe
// Description : Multi-lane FP classifier with a one-entry ready/valid output
//               register and sticky per-class flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int LANES  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*CLS_W-1:0]                out_class,
    output logic                                  out_any_nan,
    input  logic                                  clr_sticky,
    output logic [CLS_W-1:0]                      sticky
);

    localparam int FP_W = SIGN_W + EXPO_W + MANT_W;

    cls_t                   w_lane_cls [LANES];
    logic [LANES*CLS_W-1:0] w_new_class;
    logic                   w_new_nan;
    cls_t                   w_beat_or;
    logic                   w_accept;
    logic                   w_transfer;

    logic                   r_out_valid;
    logic [LANES*CLS_W-1:0] r_out_class;
    logic                   r_out_any_nan;
    cls_t                   r_sticky;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            fp_class_lane #(
                .SIGN_W (SIGN_W),
                .EXPO_W (EXPO_W),
                .MANT_W (MANT_W)
            ) u_lane (
                .sign (in_data[k*FP_W+EXPO_W+MANT_W +: SIGN_W]),
                .expo (in_data[k*FP_W+MANT_W +: EXPO_W]),
                .mant (in_data[k*FP_W +: MANT_W]),
                .cls  (w_lane_cls[k])
            );
        end
    endgenerate

    always_comb begin
        w_new_class = '0;
        w_new_nan   = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_new_class[k*CLS_W +: CLS_W] = w_lane_cls[k];
            w_new_nan = w_new_nan | w_lane_cls[k][CLS_SNAN] | w_lane_cls[k][CLS_QNAN];
        end
    end

    // Class summary of the beat currently held in the output register
    always_comb begin
        w_beat_or = '0;
        for (int k = 0; k < LANES; k++) begin
            w_beat_or = w_beat_or | r_out_class[k*CLS_W +: CLS_W];
        end
    end

    assign in_ready   = !rst && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_transfer = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_class   <= '0;
            r_out_any_nan <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_class   <= w_new_class;
            r_out_any_nan <= w_new_nan;
        end else if (w_transfer) begin
            r_out_valid   <= 1'b0;
        end
    end

    // A clear in a transfer cycle keeps only that beat's classes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (clr_sticky) begin
            r_sticky <= w_transfer ? w_beat_or : '0;
        end else if (w_transfer) begin
            r_sticky <= r_sticky | w_beat_or;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_class   = r_out_class;
    assign out_any_nan = r_out_any_nan;
    assign sticky      = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fp_class_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_class_pipe
// Description : Directed self-checking bench for fp_class_pipe (FP32 x4, FP16 x1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_class_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [39:0]  out_class;
    logic         out_any_nan;
    logic         clr_sticky;
    logic [9:0]   sticky;

    logic         in_valid16;
    logic         in_ready16;
    logic [15:0]  in_data16;
    logic         out_valid16;
    logic         out_ready16;
    logic [9:0]   out_class16;
    logic         out_any_nan16;
    logic         clr_sticky16;
    logic [9:0]   sticky16;

    int vec  = 0;
    int errs = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    fp_class_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LANES(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_any_nan (out_any_nan),
        .clr_sticky  (clr_sticky),
        .sticky      (sticky)
    );

    fp_class_pipe #(.SIGN_W(1), .EXPO_W(5), .MANT_W(10), .LANES(1)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .in_data     (in_data16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .out_class   (out_class16),
        .out_any_nan (out_any_nan16),
        .clr_sticky  (clr_sticky16),
        .sticky      (sticky16)
    );

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xfer_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model32(input logic [31:0] v);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = v[31];
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) return s ? 10'h001 : 10'h080;
            return m[22] ? 10'h200 : 10'h100;
        end
        if (e == 8'h00) begin
            if (m == 23'd0) return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = r[30:23];
        endcase
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       m = 23'd0;
            1:       m = r[22:0];
            2:       m = {1'b0, r[21:0]};
            default: m = r[22:0] | 23'd1;
        endcase
        r = $urandom;
        return {r[0], e, m};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        #1;
        vec++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tick();
        tick();
        vec++;
        if ({out_valid, out_class, out_any_nan, sticky} !== 52'd0) begin
            errs++;
            $display("FAIL reset_outputs: valid=%0b class=%h nan=%0b sticky=%h want all 0",
                     out_valid, out_class, out_any_nan, sticky);
        end
        rst = 1'b0;
        #1;
        vec++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic;
        in_data   = {32'hFF80_0000, 32'h7F80_0000, 32'h8000_0000, 32'h0000_0000};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vec++;
        if (out_valid !== 1'b1 || out_class !== {10'h001, 10'h080, 10'h008, 10'h010}) begin
            errs++; $display("FAIL basic_class: valid=%0b class=%h want 1 %h", out_valid, out_class,
                             {10'h001, 10'h080, 10'h008, 10'h010});
        end
        vec++;
        if (out_any_nan !== 1'b0) begin errs++; $display("FAIL basic_nan: got %0b want 0", out_any_nan); end
        tick();
        vec++;
        if (sticky !== 10'h099 || out_valid !== 1'b0) begin
            errs++; $display("FAIL basic_sticky: sticky=%h valid=%0b want 099 0", sticky, out_valid);
        end
    endtask

    task automatic test_nan;
        in_data   = {32'h0000_0001, 32'hFFC0_0001, 32'h7F80_0001, 32'h7FC0_0000};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vec++;
        if (out_class !== {10'h020, 10'h200, 10'h100, 10'h200}) begin
            errs++; $display("FAIL nan_class: got %h want %h", out_class, {10'h020, 10'h200, 10'h100, 10'h200});
        end
        vec++;
        if (out_any_nan !== 1'b1) begin errs++; $display("FAIL nan_flag: got %0b want 1", out_any_nan); end
        tick();
        vec++;
        if (sticky !== 10'h3B9) begin errs++; $display("FAIL nan_sticky: got %h want 3b9", sticky); end
    endtask

    task automatic test_sticky_clr;
        in_data   = {4{32'h3F80_0000}};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b1;
        tick();
        vec++;
        if (sticky !== 10'h040) begin errs++; $display("FAIL clr_with_xfer: got %h want 040", sticky); end
        tick();
        clr_sticky = 1'b0;
        vec++;
        if (sticky !== 10'h000) begin errs++; $display("FAIL clr_alone: got %h want 000", sticky); end
    endtask

    task automatic test_backpressure;
        int          base;
        logic [39:0] held;
        base      = xfer_cnt;
        in_data   = {32'hBF80_0000, 32'h0040_0000, 32'h8000_0001, 32'h3F80_0000};
        held      = {10'h002, 10'h020, 10'h004, 10'h040};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_data = {4{32'h7F80_0000}};
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== held) begin
                errs++; $display("FAIL stall_%0d: ready=%0b valid=%0b class=%h want 0 1 %h",
                                 i, in_ready, out_valid, out_class, held);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        vec++;
        if (out_valid !== 1'b0 || xfer_cnt - base !== 1) begin
            errs++; $display("FAIL stall_release: valid=%0b xfers=%0d want 0 1", out_valid, xfer_cnt - base);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base      = xfer_cnt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = {4{32'h3F80_0000 + i}};
            #1;
            vec++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready_%0d: got %0b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        vec++;
        if (xfer_cnt - base !== 16) begin
            errs++; $display("FAIL stream_xfers: got %0d want 16", xfer_cnt - base);
        end
    endtask

    task automatic test_random;
        logic [39:0] q[$];
        logic [39:0] exp_beat;
        logic [39:0] front;
        logic [31:0] lane;
        int acc = 0;
        int xf  = 0;
        int cyc = 0;
        while ((acc < 20 || q.size() > 0) && cyc < 400) begin
            in_valid  = (acc < 20) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 4; k++) begin
                lane = rand_fp();
                in_data[k*32 +: 32]  = lane;
                exp_beat[k*10 +: 10] = model32(lane);
            end
            #1;
            if (out_valid && out_ready) begin
                vec++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL rand_extra_beat: class=%h with empty model", out_class);
                end else begin
                    front = q.pop_front();
                    xf++;
                    if (out_class !== front) begin
                        errs++; $display("FAIL rand_beat_%0d: got %h want %h", xf, out_class, front);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(exp_beat);
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vec++;
        if (acc != 20 || xf != 20 || q.size() != 0) begin
            errs++; $display("FAIL rand_counts: accepted=%0d transferred=%0d pending=%0d want 20 20 0",
                             acc, xf, q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int base;
        in_data   = {4{32'h7FC0_0000}};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        base     = xfer_cnt;
        rst      = 1'b1;
        #1;
        vec++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_mid_ready: got %0b want 0", in_ready); end
        tick();
        vec++;
        if ({out_valid, out_class, out_any_nan, sticky} !== 52'd0 || xfer_cnt != base) begin
            errs++; $display("FAIL rst_mid_outputs: valid=%0b class=%h nan=%0b sticky=%h xfers=%0d want all 0",
                             out_valid, out_class, out_any_nan, sticky, xfer_cnt - base);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fp16;
        out_ready16 = 1'b1;
        in_data16   = 16'h7E00;
        in_valid16  = 1'b1;
        tick();
        vec++;
        if (out_class16 !== 10'h200 || out_any_nan16 !== 1'b1) begin
            errs++; $display("FAIL fp16_qnan: class=%h nan=%0b want 200 1", out_class16, out_any_nan16);
        end
        in_data16 = 16'h0001;
        tick();
        in_valid16 = 1'b0;
        vec++;
        if (out_class16 !== 10'h020 || out_any_nan16 !== 1'b0) begin
            errs++; $display("FAIL fp16_sub: class=%h nan=%0b want 020 0", out_class16, out_any_nan16);
        end
        tick();
        vec++;
        if (sticky16 !== 10'h220 || out_valid16 !== 1'b0) begin
            errs++; $display("FAIL fp16_sticky: sticky=%h valid=%0b want 220 0", sticky16, out_valid16);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_sticky   = 1'b0;
        in_valid16   = 1'b0;
        in_data16    = '0;
        out_ready16  = 1'b0;
        clr_sticky16 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_nan();
        test_sticky_clr();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_fp16();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
